// File: rtl/rv32_mem_arbiter_pkg.sv
// rv32_mem_arbiter_pkg: state and last-grant encodings shared by the memory arbiter.
package rv32_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        RV32_ARB_IDLE        = 2'd0,
        RV32_ARB_GRANT_INSTR = 2'd1,
        RV32_ARB_GRANT_DATA  = 2'd2
    } rv32_arb_state_e;

    typedef enum logic {
        RV32_ARB_LAST_INSTR = 1'b0,
        RV32_ARB_LAST_DATA  = 1'b1
    } rv32_arb_last_e;

endpackage

// File: rtl/rv32_mem_timeout.sv
// rv32_mem_timeout: per-grant wait counter that ends a hung bus transaction.
module rv32_mem_timeout #(
    parameter int TIMEOUT_CYCLES = 255,
    localparam int TIMEOUT_WIDTH = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_active,
    input  logic i_ready,
    output logic o_timeout
);

    // A zero TIMEOUT_CYCLES still needs a one-bit counter to stay legal.
    localparam int CW = (TIMEOUT_WIDTH < 1) ? 1 : TIMEOUT_WIDTH;
    localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    assign o_timeout = (TIMEOUT_CYCLES != 0) && i_active && !i_ready && (r_count == LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_count <= '0;
        else if (!i_active || i_ready || o_timeout)
            r_count <= '0;
        else if (r_count != '1)
            r_count <= r_count + 1'b1;
    end

endmodule

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: round-robin sharing of one memory bus between fetch and data ports,
// with grant held to completion and a timeout that turns a hung bus into a fault.
module rv32_mem_arbiter
    import rv32_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr_address_in,
    input  logic        instr_read_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_ready_out,
    output logic        instr_fault_out,
    input  logic [31:0] data_address_in,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic [31:0] data_read_value_out,
    output logic        data_ready_out,
    output logic        data_fault_out,
    output logic [31:0] mem_address_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [3:0]  mem_write_mask_out,
    output logic [31:0] mem_write_value_out,
    input  logic [31:0] mem_read_value_in,
    input  logic        mem_ready_in,
    input  logic        mem_fault_in,
    output logic        timeout_out
);

    rv32_arb_state_e r_state, w_next;
    rv32_arb_last_e  r_last;
    logic w_instr_req, w_data_req, w_gi, w_gd, w_expired, w_done;

    assign w_instr_req = instr_read_in;
    assign w_data_req  = data_read_in | data_write_in;
    assign w_gi        = (r_state == RV32_ARB_GRANT_INSTR);
    assign w_gd        = (r_state == RV32_ARB_GRANT_DATA);
    assign w_done      = (w_gi | w_gd) & (mem_ready_in | w_expired);
    assign timeout_out = w_expired;

    rv32_mem_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_active  (w_gi | w_gd),
        .i_ready   (mem_ready_in),
        .o_timeout (w_expired)
    );

    // On completion the finishing port's own request is ignored so the other side gets its turn.
    always_comb begin
        w_next = (r_state == RV32_ARB_IDLE) ?
                     ((w_instr_req && w_data_req) ?
                          ((r_last == RV32_ARB_LAST_INSTR) ? RV32_ARB_GRANT_DATA : RV32_ARB_GRANT_INSTR) :
                      w_instr_req ? RV32_ARB_GRANT_INSTR :
                      w_data_req  ? RV32_ARB_GRANT_DATA  : RV32_ARB_IDLE) :
                 w_gi ? (w_done ? (w_data_req  ? RV32_ARB_GRANT_DATA  : RV32_ARB_IDLE) : RV32_ARB_GRANT_INSTR) :
                 w_gd ? (w_done ? (w_instr_req ? RV32_ARB_GRANT_INSTR : RV32_ARB_IDLE) : RV32_ARB_GRANT_DATA) :
                 RV32_ARB_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RV32_ARB_IDLE;
            r_last  <= RV32_ARB_LAST_INSTR;
        end else begin
            r_state <= w_next;
            r_last  <= (w_next == RV32_ARB_GRANT_INSTR) ? RV32_ARB_LAST_INSTR :
                       (w_next == RV32_ARB_GRANT_DATA)  ? RV32_ARB_LAST_DATA  : r_last;
        end
    end

    always_comb begin
        mem_address_out      = w_gi ? instr_address_in : w_gd ? data_address_in : 32'd0;
        mem_read_out         = w_gi | (w_gd & data_read_in);
        mem_write_out        = w_gd & data_write_in;
        mem_write_mask_out   = w_gd ? data_write_mask_in : 4'd0;
        mem_write_value_out  = w_gd ? data_write_value_in : 32'd0;
        instr_ready_out      = w_gi & w_done;
        data_ready_out       = w_gd & w_done;
        instr_read_value_out = instr_ready_out ? mem_read_value_in : 32'd0;
        data_read_value_out  = data_ready_out ? mem_read_value_in : 32'd0;
        instr_fault_out      = instr_ready_out & (mem_ready_in ? mem_fault_in : 1'b1);
        data_fault_out       = data_ready_out & (mem_ready_in ? mem_fault_in : 1'b1);
    end

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: directed bench; completions are checked by a scoreboard monitor.
module tb_rv32_mem_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        fault;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr_address_in = '0, data_address_in = '0, data_write_value_in = '0;
    logic        instr_read_in = 1'b0, data_read_in = 1'b0, data_write_in = 1'b0;
    logic [3:0]  data_write_mask_in = '0;
    logic [31:0] mem_read_value_in = '0;
    logic        mem_ready_in = 1'b0, mem_fault_in = 1'b0;
    logic [31:0] instr_read_value_out, data_read_value_out, mem_address_out, mem_write_value_out;
    logic        instr_ready_out, instr_fault_out, data_ready_out, data_fault_out;
    logic        mem_read_out, mem_write_out, timeout_out;
    logic [3:0]  mem_write_mask_out;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];

    rv32_mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .instr_address_in     (instr_address_in),
        .instr_read_in        (instr_read_in),
        .instr_read_value_out (instr_read_value_out),
        .instr_ready_out      (instr_ready_out),
        .instr_fault_out      (instr_fault_out),
        .data_address_in      (data_address_in),
        .data_read_in         (data_read_in),
        .data_write_in        (data_write_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_write_value_in  (data_write_value_in),
        .data_read_value_out  (data_read_value_out),
        .data_ready_out       (data_ready_out),
        .data_fault_out       (data_fault_out),
        .mem_address_out      (mem_address_out),
        .mem_read_out         (mem_read_out),
        .mem_write_out        (mem_write_out),
        .mem_write_mask_out   (mem_write_mask_out),
        .mem_write_value_out  (mem_write_value_out),
        .mem_read_value_in    (mem_read_value_in),
        .mem_ready_in         (mem_ready_in),
        .mem_fault_in         (mem_fault_in),
        .timeout_out          (timeout_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push(input logic port, input logic [31:0] rdata, input logic fault, input logic to);
        exp_t e;
        e.port = port; e.rdata = rdata; e.fault = fault; e.to = to;
        q.push_back(e);
    endtask

    // Scoreboard monitor: pops one expectation per completion seen on either port.
    always @(negedge clk) begin
        exp_t e;
        if (instr_ready_out || data_ready_out) begin
            chk("sb_single_ready", {31'd0, instr_ready_out & data_ready_out}, 32'd0);
            if (q.size() == 0) begin
                chk("sb_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sb_port", {31'd0, data_ready_out}, {31'd0, e.port});
                chk("sb_rdata", data_ready_out ? data_read_value_out : instr_read_value_out, e.rdata);
                chk("sb_fault", {31'd0, data_ready_out ? data_fault_out : instr_fault_out}, {31'd0, e.fault});
                chk("sb_other_fault", {31'd0, data_ready_out ? instr_fault_out : data_fault_out}, 32'd0);
                chk("sb_timeout", {31'd0, timeout_out}, {31'd0, e.to});
            end
        end else begin
            chk("idle_rdata", instr_read_value_out | data_read_value_out, 32'd0);
            chk("idle_flags", {29'd0, instr_fault_out, data_fault_out, timeout_out}, 32'd0);
        end
    end

    initial begin
        neg();
        chk("rst_read", {31'd0, mem_read_out}, 32'd0);
        chk("rst_write", {31'd0, mem_write_out}, 32'd0);
        chk("rst_addr", mem_address_out, 32'd0);
        next();
        reset_n = 1'b1;
        // Instruction-only fetch on a zero-wait bus.
        instr_read_in = 1'b1; instr_address_in = 32'h100;
        neg(); chk("t1_no_early_strobe", {31'd0, mem_read_out}, 32'd0); next();
        mem_ready_in = 1'b1; mem_read_value_in = 32'hDEADBEEF; push(1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        neg(); chk("t1_read", {31'd0, mem_read_out}, 32'd1); chk("t1_addr", mem_address_out, 32'h100); next();
        instr_read_in = 1'b0; mem_ready_in = 1'b0;
        neg(); chk("t1_idle", {31'd0, mem_read_out}, 32'd0); next();
        // Tie out of reset: data first, then instr with no bubble, then data wins again.
        reset_n = 1'b0; next(); reset_n = 1'b1;
        instr_read_in = 1'b1; instr_address_in = 32'h200; data_read_in = 1'b1; data_address_in = 32'h300;
        neg(); next();
        mem_ready_in = 1'b1; mem_read_value_in = 32'h11112222; push(1'b1, 32'h11112222, 1'b0, 1'b0);
        neg(); chk("t2_data_first", mem_address_out, 32'h300); chk("t2_read", {31'd0, mem_read_out}, 32'd1); next();
        data_read_in = 1'b0; mem_read_value_in = 32'h33334444; push(1'b0, 32'h33334444, 1'b0, 1'b0);
        neg(); chk("t2_no_bubble", mem_address_out, 32'h200); next();
        instr_read_in = 1'b0; mem_ready_in = 1'b0;
        neg(); chk("t2_idle", {31'd0, mem_read_out}, 32'd0); next();
        instr_read_in = 1'b1; data_read_in = 1'b1; data_address_in = 32'h310;
        neg(); next();
        mem_ready_in = 1'b1; mem_read_value_in = 32'h55556666; push(1'b1, 32'h55556666, 1'b0, 1'b0);
        neg(); chk("t2_second_tie", mem_address_out, 32'h310); next();
        data_read_in = 1'b0; mem_read_value_in = 32'h77778888; push(1'b0, 32'h77778888, 1'b0, 1'b0);
        neg(); chk("t2_then_instr", mem_address_out, 32'h200); next();
        instr_read_in = 1'b0; mem_ready_in = 1'b0; mem_read_value_in = '0;
        next();
        // Store with three wait states; ready lands on the cycle the timeout would fire.
        data_write_in = 1'b1; data_address_in = 32'h400; data_write_mask_in = 4'b0100; data_write_value_in = 32'h00AB0000;
        neg(); next();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                mem_ready_in = 1'b1; push(1'b1, 32'd0, 1'b0, 1'b0);
            end
            neg();
            chk("t3_write", {31'd0, mem_write_out}, 32'd1);
            chk("t3_read", {31'd0, mem_read_out}, 32'd0);
            chk("t3_mask", {28'd0, mem_write_mask_out}, 32'h4);
            chk("t3_value", mem_write_value_out, 32'h00AB0000);
            chk("t3_addr", mem_address_out, 32'h400);
            if (i < 3) chk("t3_not_ready", {31'd0, data_ready_out}, 32'd0);
            next();
        end
        data_write_in = 1'b0; mem_ready_in = 1'b0; data_write_mask_in = '0; data_write_value_in = '0;
        neg(); chk("t3_idle", {31'd0, mem_write_out}, 32'd0); next();
        // Hung bus: timeout in the fourth granted cycle.
        data_read_in = 1'b1; data_address_in = 32'h500; mem_read_value_in = 32'hCAFEF00D;
        neg(); next();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) push(1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
            neg();
            chk("t4_read", {31'd0, mem_read_out}, 32'd1);
            if (i < 3) chk("t4_no_timeout", {31'd0, timeout_out}, 32'd0);
            next();
        end
        data_read_in = 1'b0;
        neg(); chk("t4_idle_after_timeout", {31'd0, mem_read_out}, 32'd0); next();
        // Ready coinciding with expiry on a load: ready wins.
        data_read_in = 1'b1; data_address_in = 32'h504;
        neg(); next();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                mem_ready_in = 1'b1; push(1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
            end
            neg(); next();
        end
        data_read_in = 1'b0; mem_ready_in = 1'b0;
        next();
        // Bus error on a fetch.
        instr_read_in = 1'b1; instr_address_in = 32'h700;
        neg(); next();
        mem_ready_in = 1'b1; mem_fault_in = 1'b1; mem_read_value_in = 32'h0BAD0BAD; push(1'b0, 32'h0BAD0BAD, 1'b1, 1'b0);
        neg(); next();
        instr_read_in = 1'b0; mem_ready_in = 1'b0; mem_fault_in = 1'b0;
        next();
        // Asynchronous reset during a granted fetch.
        instr_read_in = 1'b1; instr_address_in = 32'h600;
        neg(); next();
        neg(); chk("t6_granted", {31'd0, mem_read_out}, 32'd1);
        #2 reset_n = 1'b0; mem_ready_in = 1'b1;
        #1;
        chk("t6_async_drop", {31'd0, mem_read_out}, 32'd0);
        chk("t6_no_ready", {31'd0, instr_ready_out}, 32'd0);
        chk("t6_addr_zero", mem_address_out, 32'd0);
        next();
        mem_ready_in = 1'b0; reset_n = 1'b1; data_read_in = 1'b1; data_address_in = 32'h800;
        neg(); next();
        mem_ready_in = 1'b1; mem_read_value_in = 32'h9999AAAA; push(1'b1, 32'h9999AAAA, 1'b0, 1'b0);
        neg(); chk("t6_tie_data", mem_address_out, 32'h800); next();
        data_read_in = 1'b0; mem_read_value_in = 32'hBBBBCCCC; push(1'b0, 32'hBBBBCCCC, 1'b0, 1'b0);
        neg(); chk("t6_then_instr", mem_address_out, 32'h600); next();
        instr_read_in = 1'b0; mem_ready_in = 1'b0;
        next(); next();
        chk("sb_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
